// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of one registered CDB between ALU (0), BRU (1) and LSU (2)
//   clk, rst             clock and synchronous active-high reset
//   flush_i              drops every held result and suppresses the grant of that cycle
//   {alu,bru,lsu}_*      valid/ready handshake plus data, prd, rd_used, rob_tag per unit
//   cdb_*_o              registered broadcast, one valid cycle per granted result
module cdb_arbiter #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 7,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic [PREG_W-1:0] alu_prd_i,
    input  logic              alu_rd_used_i,
    input  logic [TAG_W-1:0]  alu_rob_tag_i,
    input  logic              bru_valid_i,
    output logic              bru_ready_o,
    input  logic [DATA_W-1:0] bru_data_i,
    input  logic [PREG_W-1:0] bru_prd_i,
    input  logic              bru_rd_used_i,
    input  logic [TAG_W-1:0]  bru_rob_tag_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [DATA_W-1:0] lsu_data_i,
    input  logic [PREG_W-1:0] lsu_prd_i,
    input  logic              lsu_rd_used_i,
    input  logic [TAG_W-1:0]  lsu_rob_tag_i,
    output logic              cdb_valid_o,
    output logic [DATA_W-1:0] cdb_data_o,
    output logic [PREG_W-1:0] cdb_prd_o,
    output logic              cdb_rd_used_o,
    output logic [TAG_W-1:0]  cdb_rob_tag_o,
    output logic [1:0]        cdb_src_o
);
    logic [2:0]        w_in_v;
    logic [DATA_W-1:0] w_in_data [3];
    logic [PREG_W-1:0] w_in_prd [3];
    logic [2:0]        w_in_ru;
    logic [TAG_W-1:0]  w_in_tag [3];
    logic [2:0]        r_v;
    logic [DATA_W-1:0] r_data [3];
    logic [PREG_W-1:0] r_prd [3];
    logic [2:0]        r_ru;
    logic [TAG_W-1:0]  r_tag [3];
    logic [1:0]        r_rr;
    logic              r_cdb_v;
    logic [DATA_W-1:0] r_cdb_data;
    logic [PREG_W-1:0] r_cdb_prd;
    logic              r_cdb_ru;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [1:0]        r_cdb_src;
    logic [2:0]        w_grant;
    logic [1:0]        w_gidx;
    logic              w_any;
    logic [2:0]        w_ready;
    logic [2:0]        w_acc;
    assign w_in_v       = {lsu_valid_i, bru_valid_i, alu_valid_i};
    assign w_in_ru      = {lsu_rd_used_i, bru_rd_used_i, alu_rd_used_i};
    assign w_in_data[0] = alu_data_i;
    assign w_in_data[1] = bru_data_i;
    assign w_in_data[2] = lsu_data_i;
    assign w_in_prd[0]  = alu_prd_i;
    assign w_in_prd[1]  = bru_prd_i;
    assign w_in_prd[2]  = lsu_prd_i;
    assign w_in_tag[0]  = alu_rob_tag_i;
    assign w_in_tag[1]  = bru_rob_tag_i;
    assign w_in_tag[2]  = lsu_rob_tag_i;
    // Search rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); nothing is granted during reset or flush.
    always_comb begin
        logic [2:0] w_sum;
        logic [1:0] w_idx;
        w_grant = '0;
        w_gidx  = '0;
        w_any   = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < 3; k++) begin
            w_sum = {1'b0, r_rr} + 3'(k);
            w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
            if (!w_any && r_v[w_idx] && !flush_i && !rst) begin
                w_any          = 1'b1;
                w_gidx         = w_idx;
                w_grant[w_idx] = 1'b1;
            end
        end
    end
    // A slot being granted this cycle can take a new result in the same edge.
    assign w_ready     = {3{!rst && !flush_i}} & (~r_v | w_grant);
    assign w_acc       = w_in_v & w_ready;
    assign alu_ready_o = w_ready[0];
    assign bru_ready_o = w_ready[1];
    assign lsu_ready_o = w_ready[2];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v        <= '0;
            r_rr       <= '0;
            r_cdb_v    <= 1'b0;
            r_cdb_data <= '0;
            r_cdb_prd  <= '0;
            r_cdb_ru   <= 1'b0;
            r_cdb_tag  <= '0;
            r_cdb_src  <= '0;
        end else if (flush_i) begin
            r_v     <= '0;
            r_cdb_v <= 1'b0;
        end else begin
            for (int x = 0; x < 3; x++) begin
                if (w_acc[x]) begin
                    r_v[x]    <= 1'b1;
                    r_data[x] <= w_in_data[x];
                    r_prd[x]  <= w_in_prd[x];
                    r_ru[x]   <= w_in_ru[x];
                    r_tag[x]  <= w_in_tag[x];
                end else if (w_grant[x]) begin
                    r_v[x] <= 1'b0;
                end
            end
            r_cdb_v <= w_any;
            if (w_any) begin
                r_rr       <= (w_gidx == 2'd2) ? 2'd0 : w_gidx + 2'd1;
                r_cdb_data <= r_data[w_gidx];
                r_cdb_prd  <= r_prd[w_gidx];
                r_cdb_ru   <= r_ru[w_gidx];
                r_cdb_tag  <= r_tag[w_gidx];
                r_cdb_src  <= w_gidx;
            end
        end
    end
    assign cdb_valid_o   = r_cdb_v;
    assign cdb_data_o    = r_cdb_data;
    assign cdb_prd_o     = r_cdb_prd;
    assign cdb_rd_used_o = r_cdb_ru;
    assign cdb_rob_tag_o = r_cdb_tag;
    assign cdb_src_o     = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized and directed scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
    typedef struct packed {
        logic [1:0]  s;
        logic [31:0] d;
        logic [6:0]  p;
        logic        ru;
        logic [4:0]  t;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  v_i = '0;
    logic [2:0]  rdy;
    logic [31:0] d_i [3];
    logic [6:0]  p_i [3];
    logic [2:0]  ru_i = '0;
    logic [4:0]  t_i [3];
    logic        cdb_valid;
    logic [31:0] cdb_data;
    logic [6:0]  cdb_prd;
    logic        cdb_ru;
    logic [4:0]  cdb_tag;
    logic [1:0]  cdb_src;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        q[$];
    bit          fu_v [3];
    logic [31:0] fu_d [3];
    logic [6:0]  fu_p [3];
    bit          fu_ru [3];
    logic [4:0]  fu_t [3];
    bit          m_v [3];
    exp_t        m_slot [3];
    int          m_rr = 0;
    always #5 clk = ~clk;
    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .alu_valid_i(v_i[0]), .alu_ready_o(rdy[0]), .alu_data_i(d_i[0]), .alu_prd_i(p_i[0]),
        .alu_rd_used_i(ru_i[0]), .alu_rob_tag_i(t_i[0]),
        .bru_valid_i(v_i[1]), .bru_ready_o(rdy[1]), .bru_data_i(d_i[1]), .bru_prd_i(p_i[1]),
        .bru_rd_used_i(ru_i[1]), .bru_rob_tag_i(t_i[1]),
        .lsu_valid_i(v_i[2]), .lsu_ready_o(rdy[2]), .lsu_data_i(d_i[2]), .lsu_prd_i(p_i[2]),
        .lsu_rd_used_i(ru_i[2]), .lsu_rob_tag_i(t_i[2]),
        .cdb_valid_o(cdb_valid), .cdb_data_o(cdb_data), .cdb_prd_o(cdb_prd),
        .cdb_rd_used_o(cdb_ru), .cdb_rob_tag_o(cdb_tag), .cdb_src_o(cdb_src)
    );
    task automatic offer(input int x, input logic [31:0] d, input logic [6:0] p, input bit ru, input logic [4:0] t);
        fu_v[x]  = 1'b1;
        fu_d[x]  = d;
        fu_p[x]  = p;
        fu_ru[x] = ru;
        fu_t[x]  = t;
    endtask
    task automatic rnd(input int pct);
        for (int x = 0; x < 3; x++)
            if (!fu_v[x] && int'($urandom_range(99)) < pct)
                offer(x, $urandom, 7'($urandom), 1'($urandom), 5'($urandom));
    endtask
    // One cycle: drive inputs, check ready against the model, then advance the model.
    task automatic step(input bit r, input bit f);
        int g;
        int idx;
        bit er [3];
        @(negedge clk);
        rst   = r;
        flush = f;
        for (int x = 0; x < 3; x++) begin
            v_i[x]  = fu_v[x];
            d_i[x]  = fu_d[x];
            p_i[x]  = fu_p[x];
            ru_i[x] = fu_ru[x];
            t_i[x]  = fu_t[x];
        end
        #1;
        g = -1;
        if (!r && !f)
            for (int k = 0; k < 3; k++) begin
                idx = (m_rr + k) % 3;
                if (g < 0 && m_v[idx]) g = idx;
            end
        for (int x = 0; x < 3; x++) begin
            er[x] = !r && !f && (!m_v[x] || g == x);
            vectors++;
            if (rdy[x] !== er[x]) begin
                miscompares++;
                $display("FAIL ready[%0d] got %b expected %b at %0t", x, rdy[x], er[x], $time);
            end
        end
        if (g >= 0) begin
            q.push_back(m_slot[g]);
            m_rr = (g + 1) % 3;
        end
        if (r) m_rr = 0;
        for (int x = 0; x < 3; x++) begin
            if (r || f) begin
                m_v[x]  = 1'b0;
                fu_v[x] = 1'b0;
            end else if (fu_v[x] && er[x]) begin
                m_v[x]    = 1'b1;
                m_slot[x] = '{s: 2'(x), d: fu_d[x], p: fu_p[x], ru: fu_ru[x], t: fu_t[x]};
                fu_v[x]   = 1'b0;
            end else if (g == x) begin
                m_v[x] = 1'b0;
            end
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (cdb_valid === 1'b1) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL cdb_spurious got src=%0d tag=%0d expected no broadcast at %0t", cdb_src, cdb_tag, $time);
                end else begin
                    e = q.pop_front();
                    if ({cdb_src, cdb_data, cdb_prd, cdb_ru, cdb_tag} !== e) begin
                        miscompares++;
                        $display("FAIL cdb_payload got src=%0d d=%h p=%0d ru=%b t=%0d expected src=%0d d=%h p=%0d ru=%b t=%0d at %0t",
                                 cdb_src, cdb_data, cdb_prd, cdb_ru, cdb_tag, e.s, e.d, e.p, e.ru, e.t, $time);
                    end
                end
            end else if (q.size() != 0) begin
                vectors++;
                miscompares++;
                e = q.pop_front();
                $display("FAIL cdb_missing got valid=%b expected src=%0d tag=%0d at %0t", cdb_valid, e.s, e.t, $time);
            end
        end
    end
    initial begin
        for (int x = 0; x < 3; x++) begin
            d_i[x] = '0;
            p_i[x] = '0;
            t_i[x] = '0;
            fu_d[x] = '0;
            fu_p[x] = '0;
            fu_t[x] = '0;
            m_slot[x] = '0;
        end
        step(1, 0);
        step(1, 0);
        @(posedge clk);
        #3;
        vectors++;
        if ({cdb_valid, cdb_data, cdb_prd, cdb_ru, cdb_tag, cdb_src} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b d=%h p=%0d ru=%b t=%0d s=%0d expected all zero",
                     cdb_valid, cdb_data, cdb_prd, cdb_ru, cdb_tag, cdb_src);
        end
        offer(0, 32'hDEADBEEF, 7'd17, 1'b1, 5'd3);
        idle(5);
        offer(0, 32'h1111_0000, 7'd1, 1'b1, 5'd10);
        offer(1, 32'h2222_0000, 7'd2, 1'b0, 5'd11);
        offer(2, 32'h3333_0000, 7'd3, 1'b1, 5'd12);
        idle(5);
        for (int i = 0; i < 8; i++) begin
            offer(0, $urandom, 7'($urandom), 1'b1, 5'(i));
            step(0, 0);
        end
        idle(3);
        for (int i = 0; i < 12; i++) begin
            if (!fu_v[0]) offer(0, $urandom, 7'($urandom), 1'b1, 5'(i));
            if (!fu_v[2]) offer(2, $urandom, 7'($urandom), 1'b1, 5'(i + 16));
            step(0, 0);
        end
        idle(3);
        rnd(100);
        step(0, 0);
        rnd(100);
        step(0, 1);
        step(0, 0);
        idle(3);
        offer(1, 32'hB0B0_B0B0, 7'd40, 1'b1, 5'd20);
        offer(2, 32'hC0C0_C0C0, 7'd41, 1'b1, 5'd21);
        step(0, 0);
        step(1, 0);
        offer(0, 32'hA0A0_A0A0, 7'd42, 1'b1, 5'd22);
        offer(1, 32'hB1B1_B1B1, 7'd43, 1'b0, 5'd23);
        idle(4);
        for (int i = 0; i < 3000; i++) begin
            rnd(60);
            step($urandom_range(199) == 0, $urandom_range(49) == 0);
        end
        idle(5);
        @(posedge clk);
        #3;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
